// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared RV32I decode constants: base XLEN/ILEN, the major opcodes the
// immediate generator recognises, the shift funct3 codes and the immediate
// format class enumeration carried on the decode pipeline.
// No ports (package).
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FUNCT3_SLLI = 3'b001;
    localparam logic [2:0] FUNCT3_SRLI = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH,
        IMM_Z
    } imm_type_e;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract
// Purely combinational immediate extraction: classifies an instruction by
// its opcode and produces the XLEN-wide immediate, its format class and an
// illegal-opcode flag.
// Optional feature macro: IMM_GEN_ZICSR_EN (CSR immediate forms -> IMM_Z).
// Ports:
//   instr_i   in  ILEN   raw instruction
//   imm_o     out XLEN   extended immediate
//   type_o    out 3      format class (imm_type_e)
//   illegal_o out 1      opcode not recognised
module imm_extract #(
    parameter int XLEN = rv32i_pkg::XLEN
) (
    input  logic [rv32i_pkg::ILEN-1:0] instr_i,
    output logic [XLEN-1:0]            imm_o,
    output rv32i_pkg::imm_type_e       type_o,
    output logic                       illegal_o
);
    import rv32i_pkg::*;

    // Every format is first assembled as a 32-bit value; zext selects
    // whether it is widened with zeros (shamt, CSR uimm) or with instr[31].
    logic [31:0] raw;
    logic        zext;
    logic [5:0]  shamt;

    // RV64 shifts use a 6-bit shamt, RV32 only the low five bits.
    assign shamt = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

    always_comb begin
        raw       = '0;
        zext      = 1'b0;
        type_o    = IMM_NONE;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OPCODE_OP_IMM: begin
                if (instr_i[14:12] == FUNCT3_SLLI || instr_i[14:12] == FUNCT3_SRLI) begin
                    type_o = IMM_SH;
                    raw    = {26'b0, shamt};
                    zext   = 1'b1;
                end else begin
                    type_o = IMM_I;
                    raw    = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OPCODE_LOAD, OPCODE_JALR: begin
                type_o = IMM_I;
                raw    = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPCODE_STORE: begin
                type_o = IMM_S;
                raw    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPCODE_BRANCH: begin
                type_o = IMM_B;
                raw    = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                type_o = IMM_U;
                raw    = {instr_i[31:12], 12'b0};
            end
            OPCODE_JAL: begin
                type_o = IMM_J;
                raw    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
            end
            OPCODE_MISC_MEM: begin
            end
            OPCODE_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                // funct3[2] marks the CSR forms whose rs1 field is a uimm.
                if (instr_i[14]) begin
                    type_o = IMM_Z;
                    raw    = {27'b0, instr_i[19:15]};
                    zext   = 1'b1;
                end
`endif
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
        imm_o = zext ? XLEN'(raw) : XLEN'($signed(raw));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Decode-stage immediate generator with a one-cycle output register and a
// one-entry skid slot, so in_ready depends only on registered state.
// Optional feature macro: IMM_GEN_ZICSR_EN (passed through to imm_extract).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready/in_instr/in_tag          input handshake + payload
//   out_valid/out_ready                        output handshake
//   out_imm/out_type/out_illegal/out_tag       registered result
module imm_gen_pipe #(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int TAG_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [rv32i_pkg::ILEN-1:0] in_instr,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_imm,
    output rv32i_pkg::imm_type_e       out_type,
    output logic                       out_illegal,
    output logic [TAG_W-1:0]           out_tag
);
    import rv32i_pkg::*;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_type_e        ty;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam entry_t EMPTY = '{imm: '0, ty: IMM_NONE, illegal: 1'b0, tag: '0};

    logic            ext_illegal;
    logic [XLEN-1:0] ext_imm;
    imm_type_e       ext_type;

    entry_t new_e;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   out_free;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i   (in_instr),
        .imm_o     (ext_imm),
        .type_o    (ext_type),
        .illegal_o (ext_illegal)
    );

    // Ready comes only from the skid flag so no combinational path from
    // out_ready back to in_ready exists.
    assign in_ready = !skid_valid_q && !rst;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    // The output register refills from the skid slot first (older entry),
    // otherwise from a newly accepted instruction. A stalled output sends a
    // new instruction to the skid slot instead.
    always_comb begin
        new_e        = '{imm: ext_imm, ty: ext_type, illegal: ext_illegal, tag: in_tag};
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_e;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_e;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= EMPTY;
            skid_q       <= EMPTY;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_type    = out_q.ty;
    assign out_illegal = out_q.illegal;
    assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
// checks both against a behavioural model of the immediate rules and of a
// two-entry in-order buffer.
module tb_imm_gen_pipe;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;

    logic        in_ready32, in_ready64;
    logic        out_valid32, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    imm_type_e   out_type32, out_type64;
    logic        out_illegal32, out_illegal64;
    logic [31:0] out_tag32, out_tag64;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [63:0] imm64;
        imm_type_e   ty;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] tag;
    } txn_t;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_type(out_type32),
        .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_type(out_type64),
        .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    // Reference immediate rules computed arithmetically from field values.
    function automatic void refModel(input logic [31:0] ins, input int xlen,
                                     output logic [63:0] imm, output imm_type_e ty,
                                     output logic ill);
        longint v;
        int     f3;
        v   = 0;
        ty  = IMM_NONE;
        ill = 1'b0;
        f3  = int'(ins[14:12]);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                if (ins[6:0] == 7'h13 && (f3 == 1 || f3 == 5)) begin
                    ty = IMM_SH;
                    v  = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    ty = IMM_I;
                    v  = longint'($signed(ins)) >>> 20;
                end
            end
            7'h23: begin
                ty = IMM_S;
                v  = (longint'($signed(ins)) >>> 25) * 32 + longint'(ins[11:7]);
            end
            7'h63: begin
                ty = IMM_B;
                v  = (ins[31] ? -64'sd4096 : 64'sd0) + 2048 * longint'(ins[7])
                   + 32 * longint'(ins[30:25]) + 2 * longint'(ins[11:8]);
            end
            7'h37, 7'h17: begin
                ty = IMM_U;
                v  = longint'($signed(ins & 32'hFFFF_F000));
            end
            7'h6F: begin
                ty = IMM_J;
                v  = (ins[31] ? -64'sd1048576 : 64'sd0) + 4096 * longint'(ins[19:12])
                   + 2048 * longint'(ins[20]) + 2 * longint'(ins[30:21]);
            end
            7'h0F: begin
            end
            7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
                if (ins[14]) begin
                    ty = IMM_Z;
                    v  = longint'(ins[19:15]);
                end
`endif
            end
            default: ill = 1'b1;
        endcase
        imm = v;
    endfunction

    function automatic vec_t mkVec(input logic [31:0] instr, input logic [31:0] imm32,
                                   input logic [63:0] imm64, input imm_type_e ty,
                                   input logic ill);
        vec_t v;
        v.instr = instr;
        v.imm32 = imm32;
        v.imm64 = imm64;
        v.ty    = ty;
        v.ill   = ill;
        return v;
    endfunction

    // Drives one cycle's worth of inputs; no checking here.
    task automatic applyStimulus(input logic v, input logic [31:0] ins,
                                 input logic [31:0] tg, input logic ordy);
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        compared++;
        if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b/%b want 0", in_ready32, in_ready64);
        end
        @(negedge clk);
        compared++;
        if ({out_valid32, out_imm32, out_type32, out_illegal32, out_tag32} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_state32: got v=%b imm=%h ty=%0d ill=%b tag=%h want all zero",
                     out_valid32, out_imm32, out_type32, out_illegal32, out_tag32);
        end
        compared++;
        if ({out_valid64, out_imm64, out_type64, out_illegal64, out_tag64} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_state64: got v=%b imm=%h ty=%0d ill=%b tag=%h want all zero",
                     out_valid64, out_imm64, out_type64, out_illegal64, out_tag64);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_in_ready: got %b/%b want 1", in_ready32, in_ready64);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t        vecs[$];
        logic [31:0] tg;
        vecs.push_back(mkVec(32'hFFF08113, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 1'b0));
        vecs.push_back(mkVec(32'hFE000EE3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, IMM_B, 1'b0));
        vecs.push_back(mkVec(32'h800000B7, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, IMM_U, 1'b0));
        vecs.push_back(mkVec(32'h01F09093, 32'd31, 64'd31, IMM_SH, 1'b0));
        vecs.push_back(mkVec(32'h03F09093, 32'd31, 64'd63, IMM_SH, 1'b0));
        vecs.push_back(mkVec(32'hFE20AC23, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, IMM_S, 1'b0));
        vecs.push_back(mkVec(32'hFF9FF06F, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, IMM_J, 1'b0));
        vecs.push_back(mkVec(32'h7FF12083, 32'h0000_07FF, 64'h0000_0000_0000_07FF, IMM_I, 1'b0));
        vecs.push_back(mkVec(32'h0FF0000F, 32'h0, 64'h0, IMM_NONE, 1'b0));
        vecs.push_back(mkVec(32'h0000007F, 32'h0, 64'h0, IMM_NONE, 1'b1));
        vecs.push_back(mkVec(32'h00000073, 32'h0, 64'h0, IMM_NONE, 1'b0));
`ifdef IMM_GEN_ZICSR_EN
        vecs.push_back(mkVec(32'h3400D0F3, 32'd1, 64'd1, IMM_Z, 1'b0));
`else
        vecs.push_back(mkVec(32'h3400D0F3, 32'h0, 64'h0, IMM_NONE, 1'b0));
`endif
        foreach (vecs[i]) begin
            tg = $urandom;
            applyStimulus(1'b1, vecs[i].instr, tg, 1'b1);
            @(negedge clk);
            compared++;
            if (out_valid32 !== 1'b1 || out_valid64 !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL dir_valid %h: got %b/%b want 1", vecs[i].instr, out_valid32, out_valid64);
            end
            compared++;
            if (out_imm32 !== vecs[i].imm32 || out_type32 !== vecs[i].ty || out_illegal32 !== vecs[i].ill) begin
                mismatched++;
                $display("[TB] FAIL dir32 %h: got imm=%h ty=%0d ill=%b want imm=%h ty=%0d ill=%b",
                         vecs[i].instr, out_imm32, out_type32, out_illegal32, vecs[i].imm32, vecs[i].ty, vecs[i].ill);
            end
            compared++;
            if (out_imm64 !== vecs[i].imm64 || out_type64 !== vecs[i].ty || out_illegal64 !== vecs[i].ill) begin
                mismatched++;
                $display("[TB] FAIL dir64 %h: got imm=%h ty=%0d ill=%b want imm=%h ty=%0d ill=%b",
                         vecs[i].instr, out_imm64, out_type64, out_illegal64, vecs[i].imm64, vecs[i].ty, vecs[i].ill);
            end
            compared++;
            if (out_tag32 !== tg || out_tag64 !== tg) begin
                mismatched++;
                $display("[TB] FAIL dir_tag %h: got %h/%h want %h", vecs[i].instr, out_tag32, out_tag64, tg);
            end
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 32'hFFF08113, 32'd1, 1'b0);
        compared++;
        if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_ready1: got %b/%b want 1", in_ready32, in_ready64);
        end
        @(negedge clk);
        applyStimulus(1'b1, 32'hFE000EE3, 32'd2, 1'b0);
        compared++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b1 || out_tag32 !== 32'd1 || out_tag64 !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got rdy=%b v=%b tag=%h/%h want rdy=1 v=1 tag=1",
                     in_ready32, out_valid32, out_tag32, out_tag64);
        end
        @(negedge clk);
        applyStimulus(1'b1, 32'h01F09093, 32'd3, 1'b0);
        compared++;
        if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_full_ready: got %b/%b want 0", in_ready32, in_ready64);
        end
        @(negedge clk);
        compared++;
        if (in_ready32 !== 1'b0 || out_tag32 !== 32'd1 || out_type32 !== IMM_I) begin
            mismatched++;
            $display("[TB] FAIL b2b_hold: got rdy=%b tag=%h ty=%0d want rdy=0 tag=1 ty=%0d",
                     in_ready32, out_tag32, out_type32, IMM_I);
        end
        out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (out_valid32 !== 1'b1 || out_tag32 !== 32'd2 || out_tag64 !== 32'd2 || out_type64 !== IMM_B || in_ready64 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_drain2: got v=%b tag=%h/%h ty=%0d rdy=%b want v=1 tag=2 ty=%0d rdy=1",
                     out_valid32, out_tag32, out_tag64, out_type64, in_ready64, IMM_B);
        end
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        compared++;
        if (out_valid64 !== 1'b1 || out_tag32 !== 32'd3 || out_tag64 !== 32'd3 || out_type32 !== IMM_SH || out_imm32 !== 32'd31) begin
            mismatched++;
            $display("[TB] FAIL b2b_drain3: got v=%b tag=%h/%h ty=%0d imm=%h want v=1 tag=3 ty=%0d imm=1f",
                     out_valid64, out_tag32, out_tag64, out_type32, out_imm32, IMM_SH);
        end
        @(negedge clk);
        compared++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_empty: got %b/%b want 0", out_valid32, out_valid64);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                                  7'h17, 7'h6F, 7'h0F, 7'h73, 7'h7F, 7'h0B};
        txn_t        q[$];
        txn_t        t;
        logic [63:0] e32, e64;
        imm_type_e   ty32, ty64;
        logic        il32, il64;
        logic        iv, ordy;
        logic [31:0] ins;
        int          cnt;
        for (int c = 0; c < 1500; c++) begin
            iv   = (c >= 1490) ? 1'b0 : ($urandom_range(0, 9) < 7);
            ordy = (c >= 1490) ? 1'b1 : ($urandom_range(0, 9) < 6);
            ins  = $urandom;
            ins[6:0] = ops[$urandom_range(0, 11)];
            applyStimulus(iv, ins, $urandom, ordy);
            cnt = q.size();
            compared++;
            if (in_ready32 !== (cnt < 2) || in_ready64 !== (cnt < 2)) begin
                mismatched++;
                $display("[TB] FAIL rnd_ready c=%0d: got %b/%b want %b", c, in_ready32, in_ready64, cnt < 2);
            end
            compared++;
            if (out_valid32 !== (cnt > 0) || out_valid64 !== (cnt > 0)) begin
                mismatched++;
                $display("[TB] FAIL rnd_valid c=%0d: got %b/%b want %b", c, out_valid32, out_valid64, cnt > 0);
            end
            if (cnt > 0) begin
                refModel(q[0].instr, 32, e32, ty32, il32);
                refModel(q[0].instr, 64, e64, ty64, il64);
                compared++;
                if (out_imm32 !== e32[31:0] || out_type32 !== ty32 || out_illegal32 !== il32) begin
                    mismatched++;
                    $display("[TB] FAIL rnd32 %h: got imm=%h ty=%0d ill=%b want imm=%h ty=%0d ill=%b",
                             q[0].instr, out_imm32, out_type32, out_illegal32, e32[31:0], ty32, il32);
                end
                compared++;
                if (out_imm64 !== e64 || out_type64 !== ty64 || out_illegal64 !== il64) begin
                    mismatched++;
                    $display("[TB] FAIL rnd64 %h: got imm=%h ty=%0d ill=%b want imm=%h ty=%0d ill=%b",
                             q[0].instr, out_imm64, out_type64, out_illegal64, e64, ty64, il64);
                end
                compared++;
                if (out_tag32 !== q[0].tag || out_tag64 !== q[0].tag) begin
                    mismatched++;
                    $display("[TB] FAIL rnd_tag: got %h/%h want %h", out_tag32, out_tag64, q[0].tag);
                end
            end
            if (ordy && cnt > 0) void'(q.pop_front());
            if (iv && cnt < 2) begin
                t.instr = in_instr;
                t.tag   = in_tag;
                q.push_back(t);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 32'h0000007F, 32'hA, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'hFFF08113, 32'hB, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        compared++;
        if (in_ready32 !== 1'b0 || out_illegal32 !== 1'b1 || out_type64 !== IMM_NONE || out_imm64 !== 64'h0 || out_tag64 !== 32'hA) begin
            mismatched++;
            $display("[TB] FAIL mid_full: got rdy=%b ill=%b ty=%0d imm=%h tag=%h want rdy=0 ill=1 ty=0 imm=0 tag=a",
                     in_ready32, out_illegal32, out_type64, out_imm64, out_tag64);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_rst_ready: got %b/%b want 0", in_ready32, in_ready64);
        end
        @(negedge clk);
        compared++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || out_tag32 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL mid_rst_valid: got %b/%b tag=%h want 0 tag=0", out_valid32, out_valid64, out_tag32);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compared++;
            if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL mid_stale k=%0d: got %b/%b want 0", k, out_valid32, out_valid64);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
